// File: rtl/vm_pkg.sv
// Shared constants for the vending machine input path.
// Channel indices and default debounce sizing.
package vm_pkg;

    localparam int CNT_MAX_DEF = 500000;
    localparam int CNT_W_DEF   = 20;

    localparam int NCH    = 3;
    localparam int COIN   = 0;
    localparam int COFFEE = 1;
    localparam int SPRITE = 2;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } deb_state_e;

    // Fixed priority: coin > coffee > sprite.
    function automatic logic [NCH-1:0] pick(input logic [NCH-1:0] req);
        logic [NCH-1:0] g;
        g = '0;
        if (req[COIN]) begin
            g[COIN] = 1'b1;
        end else if (req[COFFEE]) begin
            g[COFFEE] = 1'b1;
        end else if (req[SPRITE]) begin
            g[SPRITE] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, debounce counter,
// debounced level FSM and rising-edge detect.
module btn_debounce
    import vm_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             sync1;
    logic             sync2;
    deb_state_e       state;
    deb_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             stable;
    logic             stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            state    <= ST_LOW;
            cnt      <= '0;
            stable_d <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            stable_d <= stable;
        end
    end

    // Counter only runs while the synchronized input disagrees.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        stable    = (state == ST_HIGH);
        if (sync2 != stable) begin
            if (cnt == CNT_LAST) begin
                state_nxt = sync2 ? ST_HIGH : ST_LOW;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/fsm_input_conditioner.sv
// Debounces three vending buttons and serialises their press
// events into one-cycle request pulses, coin first.
module fsm_input_conditioner
    import vm_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_coin,
    input  logic i_btn_coffee,
    input  logic i_btn_sprite,
    output logic o_coin,
    output logic o_coffee,
    output logic o_sprite
);

    logic [NCH-1:0] btn;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] pend_nxt;
    logic [NCH-1:0] req;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] out_q;

    assign btn[COIN]   = i_btn_coin;
    assign btn[COFFEE] = i_btn_coffee;
    assign btn[SPRITE] = i_btn_sprite;

    for (genvar i = 0; i < NCH; i++) begin : gen_ch
        btn_debounce #(
            .CNT_MAX(CNT_MAX),
            .CNT_W  (CNT_W)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn[i]),
            .rise (rise[i])
        );
    end

    // A rise on an already pending channel merges into that bit.
    always_comb begin
        req      = pend | rise;
        grant    = pick(req);
        pend_nxt = req & ~grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            out_q <= '0;
        end else begin
            pend  <= pend_nxt;
            out_q <= grant;
        end
    end

    assign o_coin   = out_q[COIN];
    assign o_coffee = out_q[COFFEE];
    assign o_sprite = out_q[SPRITE];

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Scoreboard bench: each press pushes its expected pulse cycle,
// a monitor pops and compares whenever an output fires.
module tb_fsm_input_conditioner;

    localparam int CM = 4;
    localparam int CW = 3;
    localparam int LAT = CM + 3;

    typedef struct {
        int         cyc;
        logic [2:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b_coin = 1'b0;
    logic b_coffee = 1'b0;
    logic b_sprite = 1'b0;
    logic o_coin;
    logic o_coffee;
    logic o_sprite;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t e;
    logic [2:0] outs;

    fsm_input_conditioner #(
        .CNT_MAX(CM),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_btn_coin  (b_coin),
        .i_btn_coffee(b_coffee),
        .i_btn_sprite(b_sprite),
        .o_coin      (o_coin),
        .o_coffee    (o_coffee),
        .o_sprite    (o_sprite)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    task automatic set_btn(input logic [2:0] v);
        b_coin   = v[0];
        b_coffee = v[1];
        b_sprite = v[2];
    endtask

    // Called at a negedge: next posedge is the first to sample.
    task automatic expect_at(input int dly, input logic [2:0] v);
        exp_t x;
        x.cyc = cyc + dly;
        x.vec = v;
        q.push_back(x);
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rst_outs();
        #1;
        check("rst_coin", o_coin, 0);
        check("rst_coffee", o_coffee, 0);
        check("rst_sprite", o_sprite, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            outs = {o_sprite, o_coffee, o_coin};
            if (outs != 3'b000) begin
                if (q.size() == 0) begin
                    check("spurious", outs, 0);
                end else begin
                    e = q.pop_front();
                    check("chan", outs, e.vec);
                    check("when", cyc, e.cyc);
                end
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("missed", cyc, e.cyc);
            end
        end
    end

    initial begin
        negs(2);
        check_rst_outs();
        @(negedge clk);
        rst_n = 1'b1;
        negs(3);

        // Clean coin press
        set_btn(3'b001);
        expect_at(LAT, 3'b001);
        negs(20);
        set_btn(3'b000);
        negs(12);

        // Coffee bounce then steady
        set_btn(3'b010);
        negs(1);
        set_btn(3'b000);
        negs(1);
        set_btn(3'b010);
        negs(1);
        set_btn(3'b000);
        negs(1);
        set_btn(3'b010);
        expect_at(LAT, 3'b010);
        negs(20);
        set_btn(3'b000);
        negs(12);

        // Sprite glitch shorter than the hold time
        set_btn(3'b100);
        negs(3);
        set_btn(3'b000);
        negs(12);

        // All three together
        set_btn(3'b111);
        expect_at(LAT, 3'b001);
        expect_at(LAT + 1, 3'b010);
        expect_at(LAT + 2, 3'b100);
        negs(20);
        set_btn(3'b000);
        negs(12);

        // Hold, release, press again
        set_btn(3'b001);
        expect_at(LAT, 3'b001);
        negs(50);
        set_btn(3'b000);
        negs(10);
        set_btn(3'b001);
        expect_at(LAT, 3'b001);
        negs(20);
        set_btn(3'b000);
        negs(12);

        // Reset while coffee is pending behind coin
        set_btn(3'b011);
        expect_at(LAT, 3'b001);
        negs(LAT);
        rst_n = 1'b0;
        check_rst_outs();
        set_btn(3'b000);
        negs(2);
        rst_n = 1'b1;
        negs(20);

        // Reset two cycles into a coin debounce
        set_btn(3'b001);
        negs(2);
        rst_n = 1'b0;
        check_rst_outs();
        set_btn(3'b000);
        negs(2);
        rst_n = 1'b1;
        negs(20);

        // Sprite already held at reset release
        rst_n = 1'b0;
        set_btn(3'b100);
        negs(2);
        rst_n = 1'b1;
        expect_at(LAT, 3'b100);
        negs(20);
        set_btn(3'b000);
        negs(12);

        check("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fsm_input_conditioner.md
FSM_INPUT_CONDITIONER -- requirements
Module: fsm_input_conditioner

Interface
REQ-001 Parameter CNT_MAX, default 500000, debounce hold time in clk cycles (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter CNT_W, default 20, debounce counter width; SHALL satisfy 2^CNT_W > CNT_MAX.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_btn_coin  input  1  raw coin push-button, active-high, asynchronous to clk, may bounce.
REQ-006 i_btn_coffee  input  1  raw coffee push-button, same properties.
REQ-007 i_btn_sprite  input  1  raw sprite push-button, same properties.
REQ-008 o_coin  output  1  one-cycle coin request pulse to the vending FSM.
REQ-009 o_coffee  output  1  one-cycle coffee request pulse.
REQ-010 o_sprite  output  1  one-cycle sprite request pulse.

Function
REQ-011 Each channel SHALL pass its raw input through a two-flop synchronizer before any other use.
REQ-012 Each channel SHALL hold a debounced level "stable" and a counter; counter clears whenever synchronized value equals stable.
REQ-013 While synchronized value differs from stable, counter SHALL increment each cycle; on the edge where counter equals CNT_MAX-1, stable SHALL take the synchronized value and counter SHALL clear.
REQ-014 Any disagreement interval shorter than CNT_MAX cycles SHALL leave stable unchanged and produce no pulse (press and release filtered identically).
REQ-015 A rise event SHALL be flagged when stable goes 0->1; falling transitions SHALL produce no event.
REQ-016 Outputs SHALL be registered; at most one of o_coin/o_coffee/o_sprite high in any cycle; each pulse exactly one cycle wide.
REQ-017 Single-press latency: with edge k the first to sample raw high and raw held high, output SHALL be high in the cycle following edge k+CNT_MAX+2 and low after edge k+CNT_MAX+3.
REQ-018 Simultaneous or overlapping rise events SHALL be recorded in a 3-bit pending register; each cycle the highest-priority of (pending OR new rises) is issued, priority coin > coffee > sprite, and its pending bit cleared.
REQ-019 A new rise on a channel whose pending bit is already set SHALL be merged (no second pulse); no rise event SHALL ever be lost otherwise.
REQ-020 Button held indefinitely SHALL yield exactly one pulse; a further pulse requires a debounced release then a debounced press.
REQ-021 Counter SHALL never exceed CNT_MAX-1 (no wrap-around).

Reset
REQ-022 On rst_n low, synchronizer flops, stable levels, counters, pending register and all outputs SHALL go to 0 immediately, independent of clk.
REQ-023 A button already held high at reset release SHALL produce one pulse after the REQ-017 latency, measured from the first post-reset edge.
REQ-024 Reset asserted mid-debounce or with pending bits set SHALL discard all partial state; no pulse from pre-reset activity SHALL appear afterwards.

Structure
REQ-025 Per-channel synchronizer + debounce counter + stable level + rise detect SHALL be a sub-module btn_debounce, instantiated three times, parameterized by CNT_MAX/CNT_W.
REQ-026 Arbiter, pending register and output registers SHALL live in the top module.
REQ-027 Default CNT_MAX, CNT_W and channel index constants (COIN=0, COFFEE=1, SPRITE=2) SHALL be defined in shared package vm_pkg for use by this block and the vending FSM bench.
REQ-028 Target size 150-250 lines RTL total.

Verification (CNT_MAX=4, CNT_W=3)
REQ-029 Clean coin press held 20 cycles -> o_coin single pulse after edge k+6, o_coffee/o_sprite stay 0.
REQ-030 Coffee bouncing 1,0,1,0 on alternate cycles then held high -> no pulse during bounce, exactly one o_coffee pulse 6 edges after the final steady rise.
REQ-031 Glitch high for 3 cycles on sprite -> no o_sprite pulse; counter returns to 0.
REQ-032 All three buttons rise on same edge -> o_coin, o_coffee, o_sprite pulses on three consecutive cycles in that order, never two high together.
REQ-033 rst_n pulsed low 2 cycles into a coin debounce with coffee pending -> outputs 0 during reset, no pulse after release while coin is low.
REQ-034 Coin held 50 cycles, released 10 cycles, pressed again -> exactly two o_coin pulses.
